// File: rtl/bp_me_mem_cmd_burst_collector.sv
// Purpose : collects a BP burst memory command (header + dword beats) into one
//           single-message output carrying the header and the whole block.
// Latency : output valid the cycle after the last beat (or after the header
//           for messages without data).
// Backpressure: while the collected message waits on mem_cmd_ready_and_i it is
//           held stable and both input channels stall (ready low).
// Ports   : clk_i/reset_i (sync, active-high); burst header channel
//           (mem_cmd_header_*); burst data channel (mem_cmd_data_*); collected
//           message out (mem_cmd_header_o, mem_cmd_data_o, mem_cmd_v_o,
//           mem_cmd_ready_and_i).
module bp_me_mem_cmd_burst_collector #(
  parameter int header_width_p = 64,
  parameter int data_width_p   = 64,
  parameter int block_width_p  = 512,
  parameter int size_lsb_p     = 0,
  parameter int has_data_bit_p = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  input  logic [header_width_p-1:0] mem_cmd_header_i,
  input  logic                      mem_cmd_header_v_i,
  output logic                      mem_cmd_header_ready_and_o,

  input  logic [data_width_p-1:0]   mem_cmd_data_i,
  input  logic                      mem_cmd_data_v_i,
  output logic                      mem_cmd_data_ready_and_o,

  output logic [header_width_p-1:0] mem_cmd_header_o,
  output logic [block_width_p-1:0]  mem_cmd_data_o,
  output logic                      mem_cmd_v_o,
  input  logic                      mem_cmd_ready_and_i
);

  localparam int n_lp           = block_width_p / data_width_p;
  localparam int lg_n_lp        = $clog2(n_lp);
  localparam int cnt_width_lp   = lg_n_lp + 1;
  localparam int dword_bytes_lp = data_width_p / 8;

  typedef enum logic [1:0] {e_header, e_data, e_send} state_e;

  state_e                    state_q,  state_d;
  logic [header_width_p-1:0] header_q, header_d;
  logic [block_width_p-1:0]  block_q,  block_d;
  logic [cnt_width_lp-1:0]   cnt_q,    cnt_d;
  logic [cnt_width_lp-1:0]   beats_q,  beats_d;

  // Beats carried by a message of 2^size bytes: a sub-dword message still
  // occupies one beat; anything larger is capped at one full block.
  function automatic logic [cnt_width_lp-1:0] beats_f(input logic [2:0] size);
    int bytes;
    int beats;
    bytes = 1 << size;
    if (bytes <= dword_bytes_lp) begin
      beats = 1;
    end else begin
      beats = bytes / dword_bytes_lp;
      if (beats > n_lp) beats = n_lp;
    end
    return cnt_width_lp'(beats);
  endfunction

  always_comb begin
    state_d  = state_q;
    header_d = header_q;
    block_d  = block_q;
    cnt_d    = cnt_q;
    beats_d  = beats_q;

    mem_cmd_header_ready_and_o = 1'b0;
    mem_cmd_data_ready_and_o   = 1'b0;
    mem_cmd_v_o                = 1'b0;

    unique case (state_q)
      e_header: begin
        // Not ready while reset is held, so no header is taken during reset.
        mem_cmd_header_ready_and_o = ~reset_i;
        if (mem_cmd_header_v_i && !reset_i) begin
          header_d = mem_cmd_header_i;
          block_d  = '0;
          cnt_d    = '0;
          beats_d  = beats_f(mem_cmd_header_i[size_lsb_p +: 3]);
          state_d  = mem_cmd_header_i[has_data_bit_p] ? e_data : e_send;
        end
      end
      e_data: begin
        mem_cmd_data_ready_and_o = 1'b1;
        if (mem_cmd_data_v_i) begin
          block_d[cnt_q[lg_n_lp-1:0]*data_width_p +: data_width_p] = mem_cmd_data_i;
          cnt_d = cnt_q + cnt_width_lp'(1);
          if (cnt_q == beats_q - cnt_width_lp'(1)) state_d = e_send;
        end
      end
      e_send: begin
        mem_cmd_v_o = 1'b1;
        if (mem_cmd_ready_and_i) state_d = e_header;
      end
      default: state_d = e_header;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_header;
      header_q <= '0;
      block_q  <= '0;
      cnt_q    <= '0;
      beats_q  <= '0;
    end else begin
      state_q  <= state_d;
      header_q <= header_d;
      block_q  <= block_d;
      cnt_q    <= cnt_d;
      beats_q  <= beats_d;
    end
  end

  assign mem_cmd_header_o = header_q;
  assign mem_cmd_data_o   = block_q;

endmodule

// File: tb/tb_bp_me_mem_cmd_burst_collector.sv
module tb_bp_me_mem_cmd_burst_collector;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [63:0]  hdr_i;
  logic         hdr_v;
  logic         hdr_rdy;
  logic [63:0]  data_i;
  logic         data_v;
  logic         data_rdy;
  logic [63:0]  hdr_o;
  logic [511:0] data_o;
  logic         mem_v;
  logic         mem_ready;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int cur_vec = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bp_me_mem_cmd_burst_collector dut (
    .clk_i                      (clk),
    .reset_i                    (reset_i),
    .mem_cmd_header_i           (hdr_i),
    .mem_cmd_header_v_i         (hdr_v),
    .mem_cmd_header_ready_and_o (hdr_rdy),
    .mem_cmd_data_i             (data_i),
    .mem_cmd_data_v_i           (data_v),
    .mem_cmd_data_ready_and_o   (data_rdy),
    .mem_cmd_header_o           (hdr_o),
    .mem_cmd_data_o             (data_o),
    .mem_cmd_v_o                (mem_v),
    .mem_cmd_ready_and_i        (mem_ready)
  );

  typedef struct {
    logic [63:0]  hdr;
    int           nb;     // beats driven (hand-derived from size)
    logic [63:0]  base;   // beat k carries base*(k+1)
    int           gaps;   // 1: random idle cycles between beats
    int           bp;     // cycles of output backpressure
    logic [511:0] exp;    // expected assembled block
  } vec_t;

  localparam int NV = 9;
  vec_t vt [NV];

  function automatic logic [63:0] mk_hdr(input int tag, input logic has_data, input logic [2:0] size);
    return {32'(tag), 28'h0, has_data, size};
  endfunction

  function automatic vec_t mk(input logic [63:0] h, input int nb, input logic [63:0] base,
                              input int gaps, input int bp, input logic [511:0] exp);
    vec_t v;
    v.hdr = h; v.nb = nb; v.base = base; v.gaps = gaps; v.bp = bp; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vec %0d): got %0h want %0h", name, cur_vec, act, exp);
    end
  endtask

  // Present a header and return once it has been accepted (#1 after the edge).
  task automatic do_header(input logic [63:0] h);
    int w;
    hdr_i = h;
    hdr_v = 1'b1;
    w = 0;
    while (!hdr_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("hdr_accept_timeout", 512'(w >= 20), 512'(0));
    @(posedge clk);
    #1 hdr_v = 1'b0;
  endtask

  task automatic run_msg(input vec_t v, input logic [63:0] next_hdr);
    int w;
    int g;
    int t0;
    int t1;
    do_header(v.hdr);
    t0 = cyc;
    for (int k = 0; k < v.nb; k++) begin
      if (v.gaps != 0) begin
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) begin
          @(negedge clk);
          chk("v_during_gap", 512'(mem_v), 512'(0));
          @(posedge clk);
          #1;
        end
      end
      data_i = v.base * 64'(k + 1);
      data_v = 1'b1;
      w = 0;
      while (!data_rdy && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("data_accept_timeout", 512'(w >= 20), 512'(0));
      chk("v_before_last_beat", 512'(mem_v), 512'(0));
      @(posedge clk);
      #1 data_v = 1'b0;
    end
    @(negedge clk);
    chk("v_after_last", 512'(mem_v), 512'(1));
    chk("data_rdy_in_send", 512'(data_rdy), 512'(0));
    chk("hdr_rdy_in_send", 512'(hdr_rdy), 512'(0));
    if (v.bp > 0) begin
      mem_ready = 1'b0;
      hdr_i = next_hdr;
      hdr_v = 1'b1;
      for (int j = 0; j < v.bp; j++) begin
        @(negedge clk);
        chk("bp_v_held", 512'(mem_v), 512'(1));
        chk("bp_data_stable", data_o, v.exp);
        chk("bp_hdr_blocked", 512'(hdr_rdy), 512'(0));
      end
      mem_ready = 1'b1;
    end
    chk("hdr_out", 512'(hdr_o), 512'(v.hdr));
    chk("data_out", data_o, v.exp);
    @(posedge clk);
    #1 t1 = cyc;
    if (v.gaps == 0 && v.bp == 0) chk("msg_cycles", 512'(t1 - t0), 512'(v.nb + 1));
    @(negedge clk);
    chk("v_after_send", 512'(mem_v), 512'(0));
    chk("hdr_rdy_after_send", 512'(hdr_rdy), 512'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout (vec %0d): got running want finished", cur_vec);
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = mk(mk_hdr(1, 1'b1, 3'd6), 8, 64'h11, 0, 0,
               {64'h88, 64'h77, 64'h66, 64'h55, 64'h44, 64'h33, 64'h22, 64'h11});
    vt[1] = mk(mk_hdr(2, 1'b0, 3'd6), 0, 64'h0, 0, 0, 512'h0);
    vt[2] = mk(mk_hdr(3, 1'b1, 3'd2), 1, 64'hDEADBEEF, 0, 0, {448'h0, 64'hDEADBEEF});
    vt[3] = mk(mk_hdr(4, 1'b1, 3'd3), 1, 64'h0123456789ABCDEF, 0, 0, {448'h0, 64'h0123456789ABCDEF});
    vt[4] = mk(mk_hdr(5, 1'b1, 3'd4), 2, 64'h1000000000000001, 0, 0,
               {384'h0, 64'h2000000000000002, 64'h1000000000000001});
    vt[5] = mk(mk_hdr(6, 1'b1, 3'd5), 4, 64'h0101010101010101, 1, 0,
               {256'h0, 64'h0404040404040404, 64'h0303030303030303,
                64'h0202020202020202, 64'h0101010101010101});
    vt[6] = mk(mk_hdr(7, 1'b1, 3'd7), 8, 64'h5, 1, 0,
               {64'h28, 64'h23, 64'h1e, 64'h19, 64'h14, 64'h0f, 64'h0a, 64'h05});
    vt[7] = mk(mk_hdr(8, 1'b1, 3'd6), 8, 64'h1111111111111111, 0, 5,
               {64'h8888888888888888, 64'h7777777777777777, 64'h6666666666666666,
                64'h5555555555555555, 64'h4444444444444444, 64'h3333333333333333,
                64'h2222222222222222, 64'h1111111111111111});
    vt[8] = mk(mk_hdr(9, 1'b1, 3'd0), 1, 64'hFF, 0, 0, {448'h0, 64'hFF});

    reset_i   = 1'b1;
    hdr_i     = '0;
    hdr_v     = 1'b0;
    data_i    = '0;
    data_v    = 1'b0;
    mem_ready = 1'b1;

    // Reset state, with a header offered that must not be taken.
    hdr_v = 1'b1;
    hdr_i = mk_hdr(99, 1'b1, 3'd6);
    repeat (3) begin
      @(negedge clk);
      chk("rst_v", 512'(mem_v), 512'(0));
      chk("rst_hdr_rdy", 512'(hdr_rdy), 512'(0));
      chk("rst_data_rdy", 512'(data_rdy), 512'(0));
      chk("rst_hdr_o", 512'(hdr_o), 512'(0));
      chk("rst_data_o", data_o, 512'(0));
    end
    hdr_v = 1'b0;
    @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    chk("post_rst_hdr_rdy", 512'(hdr_rdy), 512'(1));
    chk("post_rst_v", 512'(mem_v), 512'(0));

    // Data valid in e_header is neither accepted nor consumed.
    data_i = 64'hBAD;
    data_v = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_data_rdy", 512'(data_rdy), 512'(0));
    end

    for (int i = 0; i < NV; i++) begin
      cur_vec = i;
      run_msg(vt[i], (i + 1 < NV) ? vt[i + 1].hdr : 64'h0);
    end

    // Reset after beat 3 of 8 abandons the message.
    cur_vec = 100;
    do_header(vt[0].hdr);
    for (int k = 0; k < 3; k++) begin
      data_i = vt[0].base * 64'(k + 1);
      data_v = 1'b1;
      @(negedge clk);
      chk("midrst_data_rdy", 512'(data_rdy), 512'(1));
      @(posedge clk);
      #1 data_v = 1'b0;
    end
    reset_i = 1'b1;
    @(negedge clk);
    chk("midrst_v", 512'(mem_v), 512'(0));
    chk("midrst_hdr_rdy", 512'(hdr_rdy), 512'(0));
    @(posedge clk);
    #1 reset_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_after_v", 512'(mem_v), 512'(0));
      chk("midrst_after_data_rdy", 512'(data_rdy), 512'(0));
      chk("midrst_after_hdr_o", 512'(hdr_o), 512'(0));
      chk("midrst_after_data_o", data_o, 512'(0));
    end
    cur_vec = 4;
    run_msg(vt[4], 64'h0);
    cur_vec = 0;
    run_msg(vt[0], 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
